// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM encodings and
// default timing constants (50 MHz clock).
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEF_DB_CYCLES = 1000000;
  localparam int DEF_REP_DELAY = 25000000;
  localparam int DEF_REP_RATE  = 10000000;

  // Timing parameters of 0 behave exactly like 1.
  function automatic int eff_cycles(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronize, debounce, and generate press/release
// and auto-repeat pulses. All outputs are registered.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_RATE   = DEF_REP_RATE,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB = eff_cycles(DB_CYCLES);
  localparam int RD = eff_cycles(REP_DELAY);
  localparam int RR = eff_cycles(REP_RATE);
  localparam int CW = $clog2(max3(DB, RD, RR)) + 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(RR - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  btn_state_e    state_q;
  logic [CW-1:0] db_cnt_q, rep_cnt_q, rate_cnt_q;
  logic [CW-1:0] db_cnt_d, rep_cnt_d, rate_cnt_d;
  logic          level_q, press_q, release_q, repeat_q;
  logic          raw_sync;
  logic          p;
  logic          rel_done;
  logic          rep_active;

  // Flops reset to the raw level that means "released".
  sync_2ff #(.RST_VAL(ACTIVE_LOW ? 1'b1 : 1'b0)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (btn_raw),
    .q_o  (raw_sync)
  );

  assign p = ACTIVE_LOW ? ~raw_sync : raw_sync;

  // Saturating increments.
  assign db_cnt_d   = (db_cnt_q   == CNT_MAX) ? db_cnt_q   : db_cnt_q   + 1'b1;
  assign rep_cnt_d  = (rep_cnt_q  == CNT_MAX) ? rep_cnt_q  : rep_cnt_q  + 1'b1;
  assign rate_cnt_d = (rate_cnt_q == CNT_MAX) ? rate_cnt_q : rate_cnt_q + 1'b1;

  // Release qualification finishes this cycle; repeats are suppressed from here on.
  assign rel_done   = (state_q == RELEASE_WAIT) && !p && (db_cnt_d >= DB_LAST);
  assign rep_active = ((state_q == HELD) || (state_q == RELEASE_WAIT)) && !rel_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      rep_cnt_q  <= '0;
      rate_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;

      if (rep_active) begin
        if (rep_cnt_q != RD_LAST) begin
          rep_cnt_q  <= rep_cnt_d;
          rate_cnt_q <= '0;
          if (rep_cnt_d == RD_LAST) repeat_q <= 1'b1;
        end else if (rate_cnt_q >= RR_LAST) begin
          rate_cnt_q <= '0;
          repeat_q   <= 1'b1;
        end else begin
          rate_cnt_q <= rate_cnt_d;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (p) begin
            state_q  <= PRESS_WAIT;
            db_cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state_q <= IDLE;
          end else if (db_cnt_d >= DB_LAST) begin
            state_q    <= HELD;
            level_q    <= 1'b1;
            press_q    <= 1'b1;
            rep_cnt_q  <= '0;
            rate_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_d;
          end
        end
        HELD: begin
          if (!p) begin
            state_q  <= RELEASE_WAIT;
            db_cnt_q <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (p) begin
            state_q <= HELD;
          end else if (rel_done) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing parameters.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_level, btn_press, btn_release, btn_repeat;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .DB_CYCLES (4),
    .REP_DELAY (10),
    .REP_RATE  (3),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int k, input logic lvl, input logic prs,
                         input logic rel, input logic rep);
    chk({tag, ".level"},   k, btn_level,   lvl);
    chk({tag, ".press"},   k, btn_press,   prs);
    chk({tag, ".release"}, k, btn_release, rel);
    chk({tag, ".repeat"},  k, btn_repeat,  rep);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    tick();
    tick();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_all("idle", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Clean press, long hold with repeats, 2-cycle release blip, then clean release.
    btn_raw = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk_all("hold", k, (k >= 6 && k < 46), (k == 6), (k == 46),
              (k >= 15 && k <= 45 && ((k - 15) % 3 == 0)));
      if (k == 30) btn_raw = 1'b1;
      if (k == 32) btn_raw = 1'b0;
      if (k == 40) btn_raw = 1'b1;
    end

    // Bounce: single-cycle presses must never qualify.
    btn_raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_all("bounce", k, 1'b0, 1'b0, 1'b0, 1'b0);
      btn_raw = (k >= 8) ? 1'b1 : ((k % 2 == 1) ? 1'b1 : 1'b0);
    end

    // Reset mid-hold: outputs drop at once, no release, full requalification after.
    btn_raw = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    chk("prereset.level", 0, btn_level, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("in_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all("post_rst", k, (k >= 6), (k == 6), 1'b0, 1'b0);
    end

    // Release, then a short hold that ends before the first repeat.
    btn_raw = 1'b1;
    for (int k = 1; k <= 12; k++) tick();
    chk("released.level", 0, btn_level, 1'b0);
    btn_raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_all("short", k, (k >= 6 && k < 14), (k == 6), (k == 14), 1'b0);
      if (k == 8) btn_raw = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000, meaning the consecutive stable synchronized-input cycles needed to accept a level change (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter REP_DELAY, default 25000000, meaning the cycles from accepted press to the first repeat pulse.
REQ-003 The block SHALL have parameter REP_RATE, default 10000000, meaning the cycles between subsequent repeat pulses.
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means raw input 0 = pressed.
REQ-005 Port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-006 Port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-007 Port btn_raw, input, 1 bit: the asynchronous, bouncing push-button input.
REQ-008 Port btn_level, output, 1 bit: the debounced level, where 1 = pressed.
REQ-009 Port btn_press, output, 1 bit: a one-cycle pulse on the accepted press.
REQ-010 Port btn_release, output, 1 bit: a one-cycle pulse on the accepted release.
REQ-011 Port btn_repeat, output, 1 bit: a one-cycle auto-repeat pulse while the button is held.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer, then be polarity-normalized so that p = 1 means pressed.
REQ-013 The FSM SHALL have the states IDLE (released), PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-014 In IDLE with p=1, the FSM SHALL go to PRESS_WAIT and clear the stability counter.
REQ-015 In PRESS_WAIT with p=0, the FSM SHALL return to IDLE; with p=1 the counter increments, and on reaching DB_CYCLES-1 the FSM goes to HELD.
REQ-016 In HELD with p=0, the FSM SHALL go to RELEASE_WAIT and clear the counter.
REQ-017 In RELEASE_WAIT with p=1, the FSM SHALL return to HELD with the repeat timer unaffected; with p=0 the counter increments, and on reaching DB_CYCLES-1 the FSM goes to IDLE.
REQ-018 btn_level SHALL be registered and equal 1 exactly when the state is HELD or RELEASE_WAIT.
REQ-019 btn_press SHALL be high for exactly the one cycle in which the state enters HELD from PRESS_WAIT; btn_release SHALL be high for exactly the one cycle in which the state enters IDLE from RELEASE_WAIT.
REQ-020 Latency: for a clean edge on btn_raw, btn_level and the matching press/release pulse SHALL change on clock edge 2+DB_CYCLES after the first edge that samples the new value.
REQ-021 A glitch shorter than DB_CYCLES synchronized cycles SHALL produce no output change and no pulse.
REQ-022 The repeat timer SHALL clear on entry to HELD and count cycles while the state is HELD or RELEASE_WAIT.
REQ-023 btn_repeat SHALL pulse when the timer reaches REP_DELAY-1, then every REP_RATE cycles thereafter.
REQ-024 btn_repeat SHALL never coincide with btn_press, and SHALL be suppressed from the cycle RELEASE_WAIT completes.
REQ-025 The timers SHALL saturate and never wrap.
REQ-026 Counter widths SHALL be clog2 of the maximum of the parameters, plus 1, and SHALL be unsigned.
REQ-027 A parameter value of 0 or 1 SHALL behave as 1.
REQ-028 All outputs SHALL be registered, with no combinational path from btn_raw.

Reset
REQ-029 While rst_n=0, the state SHALL be IDLE, all counters 0, the synchronizer flops 0 in normalized polarity (released), and btn_level, btn_press, btn_release and btn_repeat 0.
REQ-030 Reset asserted mid-press SHALL force the outputs low immediately, with no release pulse.
REQ-031 After deassertion with the button held, a full DB_CYCLES qualification SHALL occur before btn_press.

Structure
REQ-032 A shared package SHALL hold the state encodings (IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3) and the default timing constants.
REQ-033 The block SHALL contain one sub-module, sync_2ff (1-bit, parameterized reset value).
REQ-034 The FSM, counters and pulse generation SHALL be in btn_conditioner, targeting 150-250 lines.

Verification (DB_CYCLES=4, REP_DELAY=10, REP_RATE=3, ACTIVE_LOW=1)
REQ-035 Clean press: btn_raw 1->0 held 30 cycles -> btn_press is a single pulse at edge 6; btn_level goes 1 at edge 6; btn_repeat pulses at edges 15, 18, 21, ...
REQ-036 Bounce: btn_raw toggles 0/1 each cycle for 8 cycles, then returns to 1 -> no pulse, and btn_level stays 0.
REQ-037 Release with bounce: while held, btn_raw goes 1 for 2 cycles, back to 0, then 1 steady -> no pulse on the 2-cycle blip; btn_release is a single pulse 6 edges after the steady rise; btn_level goes 0 in the same cycle.
REQ-038 Reset mid-hold: rst_n is pulsed low for 1 cycle during HELD -> all outputs are 0 asynchronously and no btn_release occurs; with the button still held, btn_press occurs 6 edges after rst_n rises.
REQ-039 Short hold: the button is held exactly 8 qualified cycles, then released cleanly -> one btn_press, one btn_release, and zero btn_repeat.
